// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator with a small built-in test-pattern
// source. The raster counters advance one pixel per CLK edge on which pix_ce
// is high. Every output is registered. Each output is decoded from the
// counter values held before that same edge, so sync, de, coordinates and
// colour share one pixel of latency and stay mutually aligned.
//
// Ports
//   CLK          system clock
//   RST_N        asynchronous active-low reset
//   pix_ce       pixel clock enable; the raster only moves when high
//   mode[1:0]    pattern select: 0 off, 1 white, 2 colour bars, 3 grid
//   h_sync       horizontal sync, active level given by H_POL
//   v_sync       vertical sync, active level given by V_POL
//   de           display enable, high inside the active area
//   x, y         pixel column / row, forced to 0 outside the active area
//   line_start   one-CLK strobe on the update for column 0 of every line
//   frame_start  one-CLK strobe on the update for pixel (0,0)
//   pix_valid    outputs were updated on this cycle (registered pix_ce)
//   red/green/blue  1-bit pattern colour, 0 whenever de is low
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 400,
  parameter int H_FP     = 20,
  parameter int H_SYNC   = 61,
  parameter int H_BP     = 27,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 11
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             pix_ce,
  input  logic [1:0]       mode,
  output logic             h_sync,
  output logic             v_sync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             pix_valid,
  output logic             red,
  output logic             green,
  output logic             blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Width of one colour bar; the bar index is found with constant
  // thresholds so no divider is built.
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Active levels of the sync outputs.
  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  // -------------------------------------------------------------------------
  // Raster state
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] hc_reg;
  logic [CNT_W-1:0] vc_reg;
  logic [1:0]       mode_reg;   // pattern mode latched at frame start

  logic [CNT_W-1:0] hc_next;
  logic [CNT_W-1:0] vc_next;

  always_comb begin
    hc_next = hc_reg + 1'b1;
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = '0;
      vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the current (pre-increment) position
  // -------------------------------------------------------------------------
  logic hc_zero;
  logic vc_zero;
  logic first_pix;
  logic in_active;
  logic hs_act;
  logic vs_act;

  always_comb begin
    hc_zero   = (hc_reg == '0);
    vc_zero   = (vc_reg == '0);
    first_pix = hc_zero && vc_zero;
    in_active = (hc_reg < H_ACT_END) && (vc_reg < V_ACT_END);
    hs_act    = (hc_reg >= H_SYNC_BEG) && (hc_reg < H_SYNC_END);
    // vc only moves when hc wraps, so this can only change on hc == 0
    vs_act    = (vc_reg >= V_SYNC_BEG) && (vc_reg < V_SYNC_END);
  end

  // The mode sampled on the frame-start edge already applies to pixel (0,0);
  // for every other pixel of the frame the latched copy is used, so a
  // mid-frame change cannot tear the picture.
  logic [1:0] mode_eff;
  always_comb begin
    mode_eff = first_pix ? mode : mode_reg;
  end

  // -------------------------------------------------------------------------
  // Colour-bar index: thermometer of "hc >= k*BAR_W" for k = 1..7. Columns
  // past 8*BAR_W (when H_ACTIVE is not a multiple of 8) stay on bar 7.
  // -------------------------------------------------------------------------
  logic [6:0] bar_ge;

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_thr
      assign bar_ge[gi-1] = (hc_reg >= CNT_W'(gi * BAR_W));
    end
  endgenerate

  logic [2:0] bar_idx;
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (bar_ge[i]) begin
        bar_idx = 3'(i + 1);
      end
    end
  end

  // Grid: a line every 16 pixels in both directions plus a closing border on
  // the last active column and row.
  logic grid_on;
  always_comb begin
    grid_on = (hc_reg[3:0] == 4'd0) || (vc_reg[3:0] == 4'd0) ||
              (hc_reg == H_ACT_LAST) || (vc_reg == V_ACT_LAST);
  end

  logic [2:0] rgb_next;
  always_comb begin
    rgb_next = 3'b000;
    if (in_active) begin
      case (mode_eff)
        2'd1:    rgb_next = 3'b111;
        2'd2:    rgb_next = bar_idx;
        2'd3:    rgb_next = grid_on ? 3'b111 : 3'b000;
        default: rgb_next = 3'b000;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered state and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hc_reg      <= '0;
      vc_reg      <= '0;
      mode_reg    <= 2'd0;
      h_sync      <= ~H_ON;
      v_sync      <= ~V_ON;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      red         <= 1'b0;
      green       <= 1'b0;
      blue        <= 1'b0;
    end else begin
      // Strobes and pix_valid are rewritten every CLK so they stay exactly
      // one CLK wide whatever the pix_ce duty cycle.
      pix_valid   <= pix_ce;
      line_start  <= pix_ce && hc_zero;
      frame_start <= pix_ce && first_pix;

      if (pix_ce) begin
        hc_reg <= hc_next;
        vc_reg <= vc_next;
        if (first_pix) begin
          mode_reg <= mode;
        end

        h_sync <= hs_act ? H_ON : ~H_ON;
        v_sync <= vs_act ? V_ON : ~V_ON;
        de     <= in_active;
        x      <= in_active ? hc_reg : '0;
        y      <= in_active ? vc_reg : '0;
        {red, green, blue} <= rgb_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen. Two small-raster instances (opposite sync
// polarities) are checked cycle by cycle against a reference raster model
// through an expected-value queue; a default-parameter instance is checked
// for the full-size line timing. Pattern spot checks come from a table.
module tb_vga_timing_gen;

  localparam int HA = 50, HFP = 4, HS = 6, HBP = 4, HT = HA + HFP + HS + HBP; // 64
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP; // 27
  localparam int CW = 11;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       pix_ce = 1'b0;
  logic [1:0] mode = 2'd0;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          h_sync;
    logic          v_sync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          pix_valid;
    logic          red;
    logic          green;
    logic          blue;
  } vid_t;

  // ---------------- DUT A: small raster, active-low syncs ----------------
  logic a_hs, a_vs, a_de, a_ls, a_fs, a_pv, a_r, a_g, a_b;
  logic [CW-1:0] a_x, a_y;
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .H_POL(0), .V_POL(0), .CNT_W(CW)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .pix_ce(pix_ce), .mode(mode),
    .h_sync(a_hs), .v_sync(a_vs), .de(a_de), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs), .pix_valid(a_pv),
    .red(a_r), .green(a_g), .blue(a_b));

  // ---------------- DUT B: small raster, active-high syncs ---------------
  logic b_hs, b_vs, b_de, b_ls, b_fs, b_pv, b_r, b_g, b_b;
  logic [CW-1:0] b_x, b_y;
  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .H_POL(1), .V_POL(1), .CNT_W(CW)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .pix_ce(pix_ce), .mode(mode),
    .h_sync(b_hs), .v_sync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .pix_valid(b_pv),
    .red(b_r), .green(b_g), .blue(b_b));

  // ---------------- DUT D: default 508x525 raster ------------------------
  logic d_hs, d_vs, d_de, d_ls, d_fs, d_pv, d_r, d_g, d_b;
  logic [CW-1:0] d_x, d_y;
  vga_timing_gen dut_d (
    .CLK(CLK), .RST_N(RST_N), .pix_ce(pix_ce), .mode(mode),
    .h_sync(d_hs), .v_sync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .pix_valid(d_pv),
    .red(d_r), .green(d_g), .blue(d_b));

  vid_t out_a, out_b, out_d;
  assign out_a = {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs, a_pv, a_r, a_g, a_b};
  assign out_b = {b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_pv, b_r, b_g, b_b};
  assign out_d = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_pv, d_r, d_g, d_b};

  int errors = 0;
  int checks = 0;

  // ---------------- reference raster model + scoreboard ------------------
  int         m_hc = 0;
  int         m_vc = 0;
  logic [1:0] m_mode = 2'd0;
  vid_t       m_prev;
  vid_t       exp_q[$];

  function automatic vid_t reset_vec(input logic pol);
    vid_t v;
    v = '0;
    v.h_sync = ~pol;
    v.v_sync = ~pol;
    return v;
  endfunction

  task automatic check_vid(input string name, input vid_t act, input vid_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b pv=%b rgb=%b%b%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b pv=%b rgb=%b%b%b",
               name, $time, act.h_sync, act.v_sync, act.de, act.x, act.y, act.line_start,
               act.frame_start, act.pix_valid, act.red, act.green, act.blue,
               exp.h_sync, exp.v_sync, exp.de, exp.x, exp.y, exp.line_start,
               exp.frame_start, exp.pix_valid, exp.red, exp.green, exp.blue);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Compute what the DUT registers on the coming edge and queue it.
  task automatic push_expected(input logic ce);
    vid_t       e;
    logic [1:0] me;
    logic       hs_on, vs_on, grid;
    int         bar;
    if (!ce) begin
      e = m_prev;
      e.line_start  = 1'b0;
      e.frame_start = 1'b0;
      e.pix_valid   = 1'b0;
    end else begin
      e  = '0;
      me = m_mode;
      if (m_hc == 0 && m_vc == 0) begin
        me     = mode;
        m_mode = mode;
      end
      e.de   = (m_hc < HA) && (m_vc < VA);
      hs_on  = (m_hc >= HA + HFP) && (m_hc < HA + HFP + HS);
      vs_on  = (m_vc >= VA + VFP) && (m_vc < VA + VFP + VS);
      e.h_sync = ~hs_on;
      e.v_sync = ~vs_on;
      e.x = e.de ? CW'(m_hc) : '0;
      e.y = e.de ? CW'(m_vc) : '0;
      e.line_start  = (m_hc == 0);
      e.frame_start = (m_hc == 0) && (m_vc == 0);
      e.pix_valid   = 1'b1;
      if (e.de) begin
        case (me)
          2'd1: {e.red, e.green, e.blue} = 3'b111;
          2'd2: begin
            bar = m_hc / (HA / 8);
            if (bar > 7) bar = 7;
            {e.red, e.green, e.blue} = 3'(bar);
          end
          2'd3: begin
            grid = (m_hc % 16 == 0) || (m_vc % 16 == 0) || (m_hc == HA - 1) || (m_vc == VA - 1);
            {e.red, e.green, e.blue} = grid ? 3'b111 : 3'b000;
          end
          default: {e.red, e.green, e.blue} = 3'b000;
        endcase
      end
      m_hc++;
      if (m_hc == HT) begin
        m_hc = 0;
        m_vc++;
        if (m_vc == VT) m_vc = 0;
      end
    end
    m_prev = e;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    vid_t e, eb;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty t=%0t got=0 want=1", $time);
      return;
    end
    e  = exp_q.pop_front();
    eb = e;
    eb.h_sync = ~e.h_sync;
    eb.v_sync = ~e.v_sync;
    check_vid("sb_pol0", out_a, e);
    check_vid("sb_pol1", out_b, eb);
  endtask

  // One CLK: drive inputs, queue expectation, sample 1 ns after the edge.
  task automatic tick(input logic ce);
    pix_ce = ce;
    push_expected(ce);
    @(posedge CLK);
    #1;
    check_pop();
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    #1;   // mid-cycle: reset must act without a clock edge
    check_vid("reset_pol0", out_a, reset_vec(1'b0));
    check_vid("reset_pol1", out_b, reset_vec(1'b1));
    check_vid("reset_default", out_d, reset_vec(1'b0));
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_vid("reset_hold_pol0", out_a, reset_vec(1'b0));
    RST_N  = 1'b1;
    m_hc   = 0;
    m_vc   = 0;
    m_mode = 2'd0;
    m_prev = reset_vec(1'b0);
    exp_q.delete();
  endtask

  task automatic run_to_frame();
    int n = 0;
    while (!out_a.frame_start && n < 2 * HT * VT + 4) begin
      tick(1'b1);
      n++;
    end
    if (!out_a.frame_start) begin
      errors++;
      checks++;
      $display("FAIL frame_timeout got=%0d cycles want=frame_start", n);
    end
  endtask

  task automatic run_to(input int tx, input int ty, output logic ok);
    int n = 0;
    while (!(out_a.de && out_a.x == CW'(tx) && out_a.y == CW'(ty)) && n < 2 * HT * VT + 4) begin
      tick(1'b1);
      n++;
    end
    ok = out_a.de && out_a.x == CW'(tx) && out_a.y == CW'(ty);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL pos_timeout got=(%0d,%0d) want=(%0d,%0d)", out_a.x, out_a.y, tx, ty);
    end
  endtask

  typedef struct {
    logic [1:0] md;
    int         x;
    int         y;
    logic [2:0] rgb;
  } spot_t;

  spot_t spots[22];

  initial begin
    logic ok;
    int   k, hs_n, hs_first, de_n, ls2, vs_n, vs_first;

    // Spot table: bars are 6 pixels wide (50/8); columns 48,49 clamp to bar 7.
    spots[0]  = '{2'd1, 10, 3, 3'b111};
    spots[1]  = '{2'd1, 49, 19, 3'b111};
    spots[2]  = '{2'd0, 10, 3, 3'b000};
    spots[3]  = '{2'd0, 0, 0, 3'b000};
    spots[4]  = '{2'd2, 0, 0, 3'b000};
    spots[5]  = '{2'd2, 5, 1, 3'b000};
    spots[6]  = '{2'd2, 6, 1, 3'b001};
    spots[7]  = '{2'd2, 17, 2, 3'b010};
    spots[8]  = '{2'd2, 18, 2, 3'b011};
    spots[9]  = '{2'd2, 41, 2, 3'b110};
    spots[10] = '{2'd2, 42, 2, 3'b111};
    spots[11] = '{2'd2, 47, 2, 3'b111};
    spots[12] = '{2'd2, 49, 2, 3'b111};
    spots[13] = '{2'd3, 0, 0, 3'b111};
    spots[14] = '{2'd3, 32, 3, 3'b111};
    spots[15] = '{2'd3, 0, 5, 3'b111};
    spots[16] = '{2'd3, 5, 5, 3'b000};
    spots[17] = '{2'd3, 16, 5, 3'b111};
    spots[18] = '{2'd3, 15, 7, 3'b000};
    spots[19] = '{2'd3, 49, 7, 3'b111};
    spots[20] = '{2'd3, 5, 16, 3'b111};
    spots[21] = '{2'd3, 5, 19, 3'b111};

    @(posedge CLK); #1;
    apply_reset();

    // ---- default raster: first update and line timing ----
    tick(1'b1);
    check_int("first_update_flags", int'({d_de, d_fs, d_ls, d_pv}), 4'b1111);
    check_int("first_update_xy", int'(d_x) + int'(d_y), 0);
    k = 0; hs_n = 0; hs_first = -1; de_n = 0; ls2 = -1;
    while (k < 1100) begin
      if (k < 508) begin
        if (!d_hs) begin
          hs_n++;
          if (hs_first < 0) hs_first = k;
        end
        if (d_de) de_n++;
      end
      if (k > 0 && d_ls && ls2 < 0) ls2 = k;
      tick(1'b1);
      k++;
    end
    check_int("def_hsync_start", hs_first, 420);
    check_int("def_hsync_width", hs_n, 61);
    check_int("def_de_per_line", de_n, 400);
    check_int("def_line_period", ls2, 508);

    // ---- small raster: frame timing at full pix_ce ----
    run_to_frame();
    k = 0; de_n = 0; vs_n = 0; vs_first = -1;
    do begin
      if (out_a.de) de_n++;
      if (!out_a.v_sync) begin
        vs_n++;
        if (vs_first < 0) vs_first = k;
      end
      tick(1'b1);
      k++;
    end while (!out_a.frame_start && k < 4000);
    check_int("frame_period", k, HT * VT);
    check_int("de_per_frame", de_n, HA * VA);
    check_int("vsync_updates", vs_n, VS * HT);
    check_int("vsync_start", vs_first, (VA + VFP) * HT);

    // ---- pix_ce toggling: raster at half rate, strobes stay 1 CLK ----
    k = 0;
    do begin
      tick(k[0]);
      k++;
    end while (!out_a.frame_start && k < 8000);
    check_int("frame_period_half_ce", k, 2 * HT * VT);

    // ---- pattern spot table ----
    for (int i = 0; i < 22; i++) begin
      if (i == 0 || spots[i].md != spots[i-1].md) begin
        mode = spots[i].md;
        tick(1'b1);
        run_to_frame();
      end
      run_to(spots[i].x, spots[i].y, ok);
      if (ok) begin
        check_int($sformatf("spot_m%0d_x%0d_y%0d", spots[i].md, spots[i].x, spots[i].y),
                  int'({out_a.red, out_a.green, out_a.blue}), int'(spots[i].rgb));
      end
    end

    // ---- mid-frame mode change: bars hold until next frame ----
    mode = 2'd2;
    tick(1'b1);
    run_to_frame();
    run_to(0, 10, ok);
    mode = 2'd3;
    run_to(20, 12, ok);
    if (ok) check_int("switch_bar3", int'({out_a.red, out_a.green, out_a.blue}), 3);
    run_to(45, 15, ok);
    if (ok) check_int("switch_bar7", int'({out_a.red, out_a.green, out_a.blue}), 7);
    run_to(2, 19, ok);
    if (ok) check_int("switch_lastrow_bar0", int'({out_a.red, out_a.green, out_a.blue}), 0);
    run_to_frame();
    check_int("switch_grid_origin", int'({out_a.red, out_a.green, out_a.blue}), 7);
    run_to(5, 5, ok);
    if (ok) check_int("switch_grid_5_5", int'({out_a.red, out_a.green, out_a.blue}), 0);

    // ---- reset mid-frame, restart at (0,0) ----
    run_to(0, 5, ok);
    apply_reset();
    tick(1'b1);
    check_int("restart_fs_pol0", int'({out_a.frame_start, out_a.line_start, out_a.de}), 3'b111);
    check_int("restart_fs_pol1", int'({out_b.frame_start, out_b.h_sync, out_b.v_sync}), 3'b100);
    for (int i = 0; i < 200; i++) tick(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator with built-in test-pattern source. Generalises the fixed 508x525 sync generator with configurable porch, sync and active widths, configurable sync polarity, a pixel clock-enable, and pixel coordinate outputs. Adds frame and line strobes and a mode-selectable 1-bit-per-channel pattern generator. Sits between the board clock and the PIN_14..PIN_18 video pins.

Parameters:
H_ACTIVE, 400, visible pixels per line
H_FP, 20, horizontal front porch (pixels)
H_SYNC, 61, horizontal sync width (pixels)
H_BP, 27, horizontal back porch (pixels); H_TOTAL = sum = 508
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
H_POL, 0, h_sync active level (0 = active-low)
V_POL, 0, v_sync active level
CNT_W, 11, counter and coordinate width; requires H_TOTAL, V_TOTAL <= 2^CNT_W

Ports:
CLK  in  1  system clock (16 MHz)
RST_N  in  1  asynchronous active-low reset
pix_ce  in  1  pixel clock enable; raster advances only when high
mode  in  2  pattern select: 0 off, 1 white, 2 colour bars, 3 grid
h_sync  out  1  horizontal sync, polarity per H_POL
v_sync  out  1  vertical sync, polarity per V_POL
de  out  1  display enable (inside active area)
x  out  CNT_W  pixel column, 0 outside active area
y  out  CNT_W  pixel row, 0 outside active area
line_start  out  1  one-CLK strobe at column 0 of every line
frame_start  out  1  one-CLK strobe at (0,0)
pix_valid  out  1  outputs were updated this cycle
red, green, blue  out  1 each  pattern output, 0 when de=0

Behaviour:
- Reset (RST_N low, async): hc=0, vc=0; h_sync=~H_POL, v_sync=~V_POL; de, x, y, strobes, pix_valid, rgb = 0; latched mode = 0.
- Counters: on CLK edge with pix_ce=1: hc increments; hc==H_TOTAL-1 wraps to 0 and vc increments; vc==V_TOTAL-1 with hc wrap wraps vc to 0. pix_ce=0: counters and all outputs hold, except strobes and pix_valid.
- All outputs registered, decoded from pre-increment hc/vc on the same pix_ce edge (one-pixel latency; sync, de, rgb mutually aligned).
- de = (hc < H_ACTIVE) && (vc < V_ACTIVE). x = hc, y = vc when de, else 0.
- h_sync active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; v_sync likewise using V_* on vc; v_sync changes only at hc==0.
- pix_valid = registered pix_ce. line_start = pix_ce && hc==0. frame_start = pix_ce && hc==0 && vc==0. Strobes are exactly one CLK wide regardless of pix_ce duty.
- Mode latching: mode sampled only on the frame_start edge; mid-frame changes take effect at the next frame (no tearing).
- Pattern (latched mode, active area only): 0 -> 000; 1 -> 111; 2 -> bar index b = hc / (H_ACTIVE/8), clamped to 7, {red,green,blue}=b[2:0]; 3 -> 111 when hc[3:0]==0 or vc[3:0]==0 or hc==H_ACTIVE-1 or vc==V_ACTIVE-1, else 000. Division constant resolved at elaboration; no runtime divider.
- Reset mid-frame: immediate return to reset values; first pix_ce after release emits (0,0) with frame_start=1.

Test Plan:
- Defaults, pix_ce=1, release reset -> first update: de=1, x=0, y=0, frame_start=1, line_start=1; frame_start repeats every 508*525=266700 cycles.
- Line timing -> h_sync low for exactly 61 updates, starting at hc=420; de high 400 updates per active line; line_start period 508.
- Frame timing -> v_sync low during vc 490..491 (2 lines, 1016 updates) beginning at hc=0; de=0 for all of vc 480..524.
- pix_ce toggling 1/0 -> raster advances every 2 CLK; frame period 533400 CLK; strobes and pix_valid one CLK wide; outputs hold on pix_ce=0 cycles.
- mode=2 then switch to 3 at y=100 -> bars continue to end of frame (x=0..49 rgb=000, x=350..399 rgb=111); grid starts at next frame_start (x=0 and x=16 white, x=5,y=5 black).
- H_POL=1, V_POL=1, reset asserted at y=200 -> h_sync/v_sync reset to 0, outputs zero; after release timing restarts at (0,0).
